// File: rtl/cache_fill_writer.sv
// cache_fill_writer: writes returning memory words into the cache data array, then commits the tag
module cache_fill_writer #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 6,
  parameter int INDEX_W = 6,
  parameter int WORDS   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 fill_start_i,
  input  logic [15:0]                          fill_addr_i,
  input  logic                                 fill_abort_i,
  input  logic                                 mem_data_valid_i,
  input  logic [DATA_W-1:0]                    mem_data_i,
  output logic                                 data_wr_en_o,
  output logic [INDEX_W+$clog2(WORDS)-1:0]     data_wr_addr_o,
  output logic [DATA_W-1:0]                    data_wr_data_o,
  output logic                                 tag_wr_en_o,
  output logic [INDEX_W-1:0]                   tag_wr_index_o,
  output logic [TAG_W:0]                       tag_wr_data_o,
  output logic                                 fill_done_o,
  output logic                                 busy_o
);
  localparam int WORD_W = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, COMMIT = 2'd2} state_t;
  state_t               state_q, state_d;
  logic [WORD_W-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [INDEX_W-1:0]   index_q, index_d;
  logic                 unused_addr;
  assign unused_addr = ^fill_addr_i[3:0];
  // state, word counter and latched block address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      index_q <= index_d;
    end
  end
  // next state: abort dominates everything, an illegal encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    index_d = index_q;
    if (fill_abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (fill_start_i) begin
          state_d = FILL;
          cnt_d   = '0;
          tag_d   = fill_addr_i[15 -: TAG_W];
          index_d = fill_addr_i[4 +: INDEX_W];
        end
        FILL: if (mem_data_valid_i) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == WORD_W'(WORDS - 1)) ? COMMIT : FILL;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // outputs are forced to zero whenever their enable is low
  always_comb begin
    data_wr_en_o   = (state_q == FILL) & mem_data_valid_i & ~fill_abort_i;
    data_wr_addr_o = data_wr_en_o ? {index_q, cnt_q} : '0;
    data_wr_data_o = data_wr_en_o ? mem_data_i : '0;
    tag_wr_en_o    = (state_q == COMMIT) & ~fill_abort_i;
    tag_wr_index_o = tag_wr_en_o ? index_q : '0;
    tag_wr_data_o  = tag_wr_en_o ? {1'b1, tag_q} : '0;
    fill_done_o    = tag_wr_en_o;
    busy_o         = (state_q == FILL) | (state_q == COMMIT);
  end
endmodule

// File: tb/tb_cache_fill_writer.sv
// tb_cache_fill_writer: random and directed fills checked against a word-count model every cycle
module tb_cache_fill_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fill_start = 1'b0, fill_abort = 1'b0, mem_data_valid = 1'b0;
  logic [15:0] fill_addr = '0, mem_data = '0;
  logic        data_wr_en, tag_wr_en, fill_done, busy;
  logic [8:0]  data_wr_addr;
  logic [15:0] data_wr_data;
  logic [5:0]  tag_wr_index;
  logic [6:0]  tag_wr_data;
  int total = 0, bad = 0;
  cache_fill_writer dut (
    .clk(clk), .rst_n(rst_n),
    .fill_start_i(fill_start), .fill_addr_i(fill_addr), .fill_abort_i(fill_abort),
    .mem_data_valid_i(mem_data_valid), .mem_data_i(mem_data),
    .data_wr_en_o(data_wr_en), .data_wr_addr_o(data_wr_addr), .data_wr_data_o(data_wr_data),
    .tag_wr_en_o(tag_wr_en), .tag_wr_index_o(tag_wr_index), .tag_wr_data_o(tag_wr_data),
    .fill_done_o(fill_done), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a fill is in progress (busy) and has received n words; n==8 means the commit cycle
  bit       m_busy = 0;
  int       m_n = 0;
  logic [5:0] m_tag = '0, m_index = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_n = 0;
    end else if (fill_abort) begin
      m_busy = 0;
      m_n = 0;
    end else if (!m_busy) begin
      if (fill_start) begin
        m_busy = 1;
        m_n = 0;
        m_tag = fill_addr[15:10];
        m_index = fill_addr[9:4];
      end
    end else if (m_n == 8) begin
      m_busy = 0;
      m_n = 0;
    end else if (mem_data_valid) m_n++;
  end
  // per-cycle compare plus a scoreboard of what the DUT wrote
  int cyc_n = 0, writes = 0, commits = 0, last_wcyc = 0, done_cyc = 0, fall_cyc = 0;
  logic [8:0]  last_waddr = '0;
  logic [5:0]  last_tidx = '0;
  logic [6:0]  last_tdata = '0;
  logic [15:0] wmem [0:511];
  bit busy_prev = 0;
  always @(negedge clk) begin
    bit e_dwe, e_twe;
    cyc_n++;
    e_dwe = m_busy && m_n < 8 && mem_data_valid && !fill_abort;
    e_twe = m_busy && m_n == 8 && !fill_abort;
    chk("data_wr_en", 32'(data_wr_en), 32'(e_dwe));
    chk("data_wr_addr", 32'(data_wr_addr), e_dwe ? 32'({m_index, 3'(m_n)}) : 0);
    chk("data_wr_data", 32'(data_wr_data), e_dwe ? 32'(mem_data) : 0);
    chk("tag_wr_en", 32'(tag_wr_en), 32'(e_twe));
    chk("tag_wr_index", 32'(tag_wr_index), e_twe ? 32'(m_index) : 0);
    chk("tag_wr_data", 32'(tag_wr_data), e_twe ? 32'({1'b1, m_tag}) : 0);
    chk("fill_done", 32'(fill_done), 32'(e_twe));
    chk("busy", 32'(busy), 32'(m_busy));
    if (data_wr_en) begin
      wmem[data_wr_addr] = data_wr_data;
      writes++;
      last_waddr = data_wr_addr;
      last_wcyc = cyc_n;
    end
    if (tag_wr_en) begin
      commits++;
      last_tidx = tag_wr_index;
      last_tdata = tag_wr_data;
      done_cyc = cyc_n;
    end
    if (busy_prev && !busy) fall_cyc = cyc_n;
    busy_prev = busy;
  end
  task automatic cyc(input logic s, input logic [15:0] a, input logic ab, input logic v, input logic [15:0] d);
    fill_start = s; fill_addr = a; fill_abort = ab; mem_data_valid = v; mem_data = d;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 16'($urandom), 0, 0, 16'($urandom));
  endtask
  task automatic full_fill(input logic [15:0] a, input int gap, input bit fixed);
    logic [15:0] d [8];
    int w0, c0;
    w0 = writes; c0 = commits;
    cyc(1, a, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      d[i] = fixed ? 16'h1000 + 16'(i) : 16'($urandom);
      idle(gap < 0 ? $urandom_range(0, 3) : gap);
      cyc(0, 0, 0, 1, d[i]);
      chk("word_addr", 32'(last_waddr), 32'({a[9:4], 3'(i)}));
    end
    idle(3);
    chk("fill_writes", writes - w0, 8);
    chk("fill_commits", commits - c0, 1);
    chk("commit_index", 32'(last_tidx), 32'(a[9:4]));
    chk("commit_tag", 32'(last_tdata), 32'({1'b1, a[15:10]}));
    for (int i = 0; i < 8; i++) chk("wmem", 32'(wmem[{a[9:4], 3'(i)}]), 32'(d[i]));
  endtask
  initial begin
    int w0, c0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_wr", 32'({data_wr_en, tag_wr_en, fill_done}), 0);
    rst_n = 1;
    // test 1: 16'hABC4 -> tag 2A, index 3C
    full_fill(16'hABC4, 3, 1);
    chk("t1_tag_lit", 32'(last_tdata), 32'h6A);
    chk("t1_idx_lit", 32'(last_tidx), 32'h3C);
    chk("t1_word3", 32'(wmem[{6'h3C, 3'd3}]), 32'h1003);
    // test 2: back-to-back words, check commit/busy latency
    full_fill(16'($urandom), 0, 0);
    chk("t2_done_lat", done_cyc - last_wcyc, 1);
    chk("t2_busy_lat", fall_cyc - last_wcyc, 2);
    // test 3: second start during FILL is ignored
    cyc(1, 16'h5A30, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(i == 2, 16'hFFF0, 0, 1, 16'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(2);
    chk("t3_idx", 32'(last_tidx), 32'h23);
    chk("t3_tag", 32'(last_tdata), 32'h56);
    // test 4: abort after 3 words
    w0 = writes; c0 = commits;
    cyc(1, 16'h1234, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 16'($urandom));
    cyc(0, 0, 1, 1, 16'($urandom));
    idle(3);
    chk("t4_writes", writes - w0, 3);
    chk("t4_commits", commits - c0, 0);
    full_fill(16'h4321, -1, 0);
    // test 5: async reset after 5 words
    w0 = writes; c0 = commits;
    cyc(1, 16'h7770, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1, 16'($urandom));
    mem_data_valid = 1; rst_n = 0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_wr_en", 32'(data_wr_en), 0);
    chk("t5_wr_addr", 32'(data_wr_addr), 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) cyc(0, 0, 0, 1, 16'($urandom));
    chk("t5_writes", writes - w0, 5);
    chk("t5_commits", commits - c0, 0);
    // test 6: index 0 then index 63
    full_fill({6'($urandom), 6'h00, 4'h5}, -1, 0);
    chk("t6_idx0", 32'(last_tidx), 0);
    full_fill({6'($urandom), 6'h3F, 4'h0}, -1, 0);
    chk("t6_idx63", 32'(last_tidx), 32'h3F);
    // random traffic including aborts and stray starts
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 29) == 0, 1'($urandom), 16'($urandom));
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
